// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Expand a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] i_req;       // bit i: requester i wants the resource
    logic             i_release;   // owner ends its ownership (one-cycle pulse)
    logic [N_REQ-1:0] o_gnt;       // one-hot grant, zero when idle
    logic [ID_W-1:0]  o_gnt_id;    // index of the owner, zero when idle
    logic             o_gnt_valid; // any grant active
    logic             o_timeout;   // grant was force-revoked at the hold limit

    // Requester side: drives requests, observes grants.
    modport master (
        output i_req, i_release,
        input  o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );

    // Arbiter side: observes requests, drives grants.
    modport slave (
        input  i_req, i_release,
        output o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );

endinterface

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    // Doubling the vector lets a plain part-select act as a right rotate;
    // the top copy of bit 7 is never reachable, so it is left off.
    logic [2*N_REQ-2:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_enc;

    assign w_dbl = {i_req[N_REQ-2:0], i_req};
    assign w_rot = w_dbl[i_ptr +: N_REQ];

    // Lowest-index-first priority encode of the rotated vector.
    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_enc = ID_W'(i);
        end
    end

    // Undo the rotation; the 3-bit add wraps naturally mod 8.
    assign o_idx   = w_enc + i_ptr;
    assign o_found = |i_req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource among eight requesters.
// A grant is held until the owner releases, drops its request, or reaches
// MAX_HOLD cycles; every handoff passes through one idle cycle.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,  // 2..255 consecutive grant cycles
    parameter int CNT_W    = 8    // 2**CNT_W > MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           r_state, w_state_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_hold, w_hold_nxt;
    logic             w_timeout_nxt;

    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id, w_gnt_id_nxt;
    logic             r_gnt_valid, w_gnt_valid_nxt;
    logic             r_timeout;

    logic             w_found;
    logic [ID_W-1:0]  w_pick;
    logic             w_exit_rel;
    logic             w_exit_lim;

    rr_pick8 u_pick (
        .i_req   (bus.i_req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Voluntary exit (release or owner drop) takes precedence over the limit,
    // so a coincident limit hit is reported as a normal release.
    assign w_exit_rel = bus.i_release | ~bus.i_req[r_owner];
    assign w_exit_lim = (r_hold == HOLD_LAST);

    // FSM state and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, watch exit conditions in GRANT.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick;
                    w_ptr_nxt   = w_pick + ID_W'(1);
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                w_hold_nxt = r_hold + CNT_W'(1);
                if (w_exit_rel || w_exit_lim) begin
                    w_state_nxt   = ST_IDLE;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = w_exit_lim & ~w_exit_rel;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the state being entered.
    always_comb begin
        w_gnt_nxt       = '0;
        w_gnt_id_nxt    = '0;
        w_gnt_valid_nxt = 1'b0;
        if (w_state_nxt == ST_GRANT) begin
            w_gnt_nxt       = id2onehot(w_owner_nxt);
            w_gnt_id_nxt    = w_owner_nxt;
            w_gnt_valid_nxt = 1'b1;
        end
    end

    // Output registers keep req/release off any combinational path to outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_id    = r_gnt_id;
    assign bus.o_gnt_valid = r_gnt_valid;
    assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter8_if u_bus ();

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who owns the resource, for how many cycles so far,
    // and where the next search starts.
    bit m_act;
    int m_own;
    int m_ptr;
    int m_held;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] rq, input bit rl, input bit rs);
        int  win;
        bit  vol;
        if (rs) begin
            m_act = 0; m_own = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_act) begin
            m_to = 0;
            win  = -1;
            for (int k = 0; k < 8; k++) begin
                if (win < 0 && rq[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
            end
            if (win >= 0) begin
                m_own  = win;
                m_ptr  = (win + 1) % 8;
                m_act  = 1;
                m_held = 1;
            end
        end else begin
            vol = rl || !rq[m_own];
            if (vol || m_held == MAX_HOLD) begin
                m_act = 0;
                m_to  = !vol;
            end else begin
                m_held++;
                m_to = 0;
            end
        end
    endtask

    // Apply inputs for one clock edge, advance the model, compare outputs.
    task automatic step(input logic [7:0] rq, input bit rl, input bit rs);
        logic [7:0] e_gnt;
        logic [2:0] e_id;
        u_bus.i_req     = rq;
        u_bus.i_release = rl;
        rst             = rs;
        @(posedge clk);
        model_edge(rq, rl, rs);
        #1;
        e_gnt = m_act ? 8'(1 << m_own) : 8'h00;
        e_id  = m_act ? 3'(m_own) : 3'd0;
        chk("gnt",       u_bus.o_gnt,       e_gnt);
        chk("gnt_id",    u_bus.o_gnt_id,    e_id);
        chk("gnt_valid", u_bus.o_gnt_valid, m_act);
        chk("timeout",   u_bus.o_timeout,   m_to);
    endtask

    initial begin
        int         n_on;
        logic [7:0] rq;
        bit         rl;
        bit         rs;

        rst             = 1'b1;
        u_bus.i_req     = '0;
        u_bus.i_release = 1'b0;

        // Reset state
        step(8'h00, 0, 1);
        step(8'h00, 0, 1);
        chk("reset_gnt",   u_bus.o_gnt, 0);
        chk("reset_valid", u_bus.o_gnt_valid, 0);

        // Single request, released after three grant cycles
        step(8'h08, 0, 0);
        chk("single_gnt", u_bus.o_gnt, 8'h08);
        chk("single_id",  u_bus.o_gnt_id, 3);
        step(8'h08, 0, 0);
        step(8'h08, 0, 0);
        step(8'h08, 1, 0);
        chk("single_rel", u_bus.o_gnt, 0);
        step(8'h18, 0, 0);
        chk("single_ptr4", u_bus.o_gnt_id, 4);
        step(8'h18, 1, 0);

        // Fairness with everyone requesting
        step(8'h00, 0, 1);
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 0, 0);
            chk("rr_id", u_bus.o_gnt_id, k % 8);
            step(8'hFF, 1, 0);
            chk("rr_gap", u_bus.o_gnt_valid, 0);
        end

        // Wrap-around from ptr=6
        step(8'h00, 0, 1);
        step(8'h20, 0, 0);
        chk("wrap_first5", u_bus.o_gnt_id, 5);
        step(8'h20, 1, 0);
        step(8'h21, 0, 0);
        chk("wrap_to0", u_bus.o_gnt_id, 0);
        step(8'h21, 1, 0);
        step(8'h21, 0, 0);
        chk("wrap_to5", u_bus.o_gnt_id, 5);
        step(8'h21, 1, 0);
        step(8'h21, 0, 0);
        chk("wrap_back0", u_bus.o_gnt_id, 0);
        step(8'h21, 1, 0);

        // Forced revoke at the hold limit, then re-grant
        step(8'h00, 0, 1);
        step(8'h02, 0, 0);
        n_on = u_bus.o_gnt_valid ? 1 : 0;
        repeat (MAX_HOLD - 1) begin
            step(8'h02, 0, 0);
            if (u_bus.o_gnt_valid) n_on++;
        end
        chk("to_len", n_on, MAX_HOLD);
        step(8'h02, 0, 0);
        chk("to_gnt",   u_bus.o_gnt, 0);
        chk("to_pulse", u_bus.o_timeout, 1);
        step(8'h02, 0, 0);
        chk("to_regnt",  u_bus.o_gnt_id, 1);
        chk("to_pulse1", u_bus.o_timeout, 0);
        step(8'h00, 0, 0);

        // Drop and release together
        step(8'h04, 0, 0);
        chk("drop_id", u_bus.o_gnt_id, 2);
        step(8'h00, 1, 0);
        chk("drop_gnt", u_bus.o_gnt, 0);
        chk("drop_to",  u_bus.o_timeout, 0);

        // Release coinciding with the limit is a normal release
        step(8'h04, 0, 0);
        repeat (MAX_HOLD - 1) step(8'h04, 0, 0);
        step(8'h04, 1, 0);
        chk("lim_rel_gnt", u_bus.o_gnt, 0);
        chk("lim_rel_to",  u_bus.o_timeout, 0);

        // Release while idle is ignored
        step(8'h00, 1, 0);
        chk("idle_rel", u_bus.o_gnt_valid, 0);
        step(8'h10, 1, 0);
        chk("idle_rel_gnt", u_bus.o_gnt_id, 4);
        step(8'h10, 1, 0);

        // Reset mid-grant
        step(8'h00, 0, 1);
        step(8'h20, 0, 0);
        chk("mid_id5", u_bus.o_gnt_id, 5);
        step(8'h20, 0, 0);
        step(8'hFF, 0, 1);
        chk("mid_gnt", u_bus.o_gnt, 0);
        chk("mid_id",  u_bus.o_gnt_id, 0);
        chk("mid_to",  u_bus.o_timeout, 0);
        step(8'hFF, 0, 0);
        chk("mid_next0", u_bus.o_gnt_id, 0);

        // Random traffic with sticky request vectors so long holds occur
        rq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) rq = 8'(1 << $urandom_range(0, 7));
                else                           rq = 8'($urandom);
            end
            rl = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(rq, rl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
